// File: rtl/rmt_ingress_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter feeding the rmt_wrapper slave stream.
// Port 0 carries data, port 1 carries config; a programmable idle gap follows every config packet.
module rmt_ingress_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CFG_PRIORITY         = 0,
  parameter int CFG_GAP              = 30,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              pkt_cnt0,
  output logic [CNT_WIDTH-1:0]              pkt_cnt1
);

  localparam int GAP_W = (CFG_GAP > 1) ? $clog2(CFG_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic [GAP_W-1:0] gap_cnt;
  logic             end0;
  logic             end1;

  assign end0 = (state == GRANT0) && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
  assign end1 = (state == GRANT1) && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == GRANT0) last_grant <= 1'b0;
      if (state == IDLE && state_nx == GRANT1) last_grant <= 1'b1;
      if (end1 && CFG_GAP > 0) gap_cnt <= GAP_W'(CFG_GAP);
      else if (state == GAP)   gap_cnt <= gap_cnt - GAP_W'(1);
      if (end0) pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
      if (end1) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
    end
  end

  // Outputs decode from the registered state; the data path is a pure mux during a grant.
  always_comb begin
    state_nx       = state;
    m_axis_tdata   = s0_axis_tdata;
    m_axis_tkeep   = s0_axis_tkeep;
    m_axis_tuser   = s0_axis_tuser;
    m_axis_tlast   = s0_axis_tlast;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          if (CFG_PRIORITY != 0) state_nx = GRANT1;
          else                   state_nx = last_grant ? GRANT0 : GRANT1;
        end else if (s0_axis_tvalid) begin
          state_nx = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_nx = GRANT1;
        end
      end
      GRANT0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_axis_tready;
        if (end0) state_nx = IDLE;
      end
      GRANT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_axis_tready;
        if (end1) state_nx = (CFG_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Self-checking bench for rmt_ingress_arbiter: three parameterisations, scoreboard of expected
// output beats in arbitration order, directed timing and counter checks.
module tb_rmt_ingress_arbiter;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int TU = 128;

  typedef struct packed {
    logic [1:0]    inst;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [TU-1:0] user;
    logic          last;
  } beat_t;

  beat_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0][1:0][DW-1:0] s_tdata;
  logic [2:0][1:0][KW-1:0] s_tkeep;
  logic [2:0][1:0][TU-1:0] s_tuser;
  logic [2:0][1:0]         s_tvalid;
  logic [2:0][1:0]         s_tlast;
  logic [2:0][1:0]         s_tready;
  logic [2:0][DW-1:0]      m_tdata;
  logic [2:0][KW-1:0]      m_tkeep;
  logic [2:0][TU-1:0]      m_tuser;
  logic [2:0]              m_tlast;
  logic [2:0]              m_tvalid;
  logic [2:0]              m_tready;
  logic [2:0]              busy;
  logic [31:0]             cnt0a, cnt1a, cnt0c, cnt1c;
  logic [1:0]              cnt0b, cnt1b;

  int checks = 0;
  int failures = 0;
  int first_drv[3][2];
  int first_acc[3][2];
  int last_acc[3][2];
  bit rand_on;

  rmt_ingress_arbiter #(.CFG_PRIORITY(0), .CFG_GAP(30)) dut_a (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s_tdata[0][0]), .s0_axis_tkeep(s_tkeep[0][0]), .s0_axis_tuser(s_tuser[0][0]),
    .s0_axis_tvalid(s_tvalid[0][0]), .s0_axis_tlast(s_tlast[0][0]), .s0_axis_tready(s_tready[0][0]),
    .s1_axis_tdata(s_tdata[0][1]), .s1_axis_tkeep(s_tkeep[0][1]), .s1_axis_tuser(s_tuser[0][1]),
    .s1_axis_tvalid(s_tvalid[0][1]), .s1_axis_tlast(s_tlast[0][1]), .s1_axis_tready(s_tready[0][1]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tuser(m_tuser[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .busy(busy[0]), .pkt_cnt0(cnt0a), .pkt_cnt1(cnt1a));

  rmt_ingress_arbiter #(.CFG_PRIORITY(0), .CFG_GAP(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s_tdata[1][0]), .s0_axis_tkeep(s_tkeep[1][0]), .s0_axis_tuser(s_tuser[1][0]),
    .s0_axis_tvalid(s_tvalid[1][0]), .s0_axis_tlast(s_tlast[1][0]), .s0_axis_tready(s_tready[1][0]),
    .s1_axis_tdata(s_tdata[1][1]), .s1_axis_tkeep(s_tkeep[1][1]), .s1_axis_tuser(s_tuser[1][1]),
    .s1_axis_tvalid(s_tvalid[1][1]), .s1_axis_tlast(s_tlast[1][1]), .s1_axis_tready(s_tready[1][1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tuser(m_tuser[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .busy(busy[1]), .pkt_cnt0(cnt0b), .pkt_cnt1(cnt1b));

  rmt_ingress_arbiter #(.CFG_PRIORITY(1), .CFG_GAP(0)) dut_c (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s_tdata[2][0]), .s0_axis_tkeep(s_tkeep[2][0]), .s0_axis_tuser(s_tuser[2][0]),
    .s0_axis_tvalid(s_tvalid[2][0]), .s0_axis_tlast(s_tlast[2][0]), .s0_axis_tready(s_tready[2][0]),
    .s1_axis_tdata(s_tdata[2][1]), .s1_axis_tkeep(s_tkeep[2][1]), .s1_axis_tuser(s_tuser[2][1]),
    .s1_axis_tvalid(s_tvalid[2][1]), .s1_axis_tlast(s_tlast[2][1]), .s1_axis_tready(s_tready[2][1]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tkeep(m_tkeep[2]), .m_axis_tuser(m_tuser[2]),
    .m_axis_tlast(m_tlast[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
    .busy(busy[2]), .pkt_cnt0(cnt0c), .pkt_cnt1(cnt1c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int port, input int p, input int b);
    logic [31:0] t;
    t = {8'(port + 1), 8'(p), 16'(b)};
    for (int k = 0; k < 16; k++) mk_data[k*32 +: 32] = t + 32'(k) * 32'h0100_0001;
  endfunction

  function automatic logic [TU-1:0] mk_user(input int port, input int p, input int b);
    logic [31:0] t;
    t = ~{8'(port + 1), 8'(p), 16'(b)};
    mk_user = {t, t ^ 32'h00ff_00ff, t, t ^ 32'hff00_ff00};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int b, input int n);
    mk_keep = (b == n - 1) ? 64'h0000_0000_000f_ffff : 64'hffff_ffff_ffff_ffff;
  endfunction

  task automatic push_pkt(input int inst, input int port, input int p, input int n);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.inst = 2'(inst);
      e.data = mk_data(port, p, b);
      e.keep = mk_keep(b, n);
      e.user = mk_user(port, p, b);
      e.last = (b == n - 1);
      sb.push_back(e);
    end
  endtask

  // Source model: presents beats back to back, advancing on each tvalid&tready handshake.
  task automatic feed(input int inst, input int port, input int base, input int npkt,
                      input int nbeats, input int delay);
    int waited;
    bit acc;
    repeat (delay) @(negedge clk);
    for (int p = base; p < base + npkt; p++) begin
      for (int b = 0; b < nbeats; b++) begin
        s_tdata[inst][port]  = mk_data(port, p, b);
        s_tkeep[inst][port]  = mk_keep(b, nbeats);
        s_tuser[inst][port]  = mk_user(port, p, b);
        s_tlast[inst][port]  = (b == nbeats - 1);
        s_tvalid[inst][port] = 1'b1;
        if (p == base && b == 0) first_drv[inst][port] = cyc;
        waited = 0;
        acc = 1'b0;
        while (!acc) begin
          #1;
          acc = s_tready[inst][port];
          if (acc && p == base && b == 0) first_acc[inst][port] = cyc + 1;
          if (acc && b == nbeats - 1) last_acc[inst][port] = cyc + 1;
          @(negedge clk);
          waited++;
          if (!acc && waited > 300) begin
            chk("feed_timeout", 64'(waited), 64'd0);
            s_tvalid[inst][port] = 1'b0;
            return;
          end
        end
      end
    end
    s_tvalid[inst][port] = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (m_tvalid[i] && m_tready[i]) begin
        beat_t e;
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk_wide("sb_data", m_tdata[i], e.data);
          chk("sb_keep", m_tkeep[i], e.keep);
          chk_wide("sb_user", DW'(m_tuser[i]), DW'(e.user));
          chk("sb_inst_last", {2'(i), m_tlast[i]}, {e.inst, e.last});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit acc;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tlast  = '0;
    s_tvalid = '0;
    m_tready = '1;
    rand_on  = 1'b0;
    rst      = 1'b1;

    // Reset held two cycles with both ports requesting
    s_tvalid[0] = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t1_m_tvalid", m_tvalid[0], 1'b0);
    chk("t1_tready", s_tready[0], 2'b00);
    chk("t1_busy", busy[0], 1'b0);
    chk("t1_cnt0", cnt0a, 32'd0);
    chk("t1_cnt1", cnt1a, 32'd0);
    s_tvalid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Single 2-beat data packet
    push_pkt(0, 0, 0, 2);
    feed(0, 0, 0, 1, 2, 0);
    chk("t2_first_latency", 64'(first_acc[0][0] - first_drv[0][0]), 64'd2);
    chk("t2_beat_spacing", 64'(last_acc[0][0] - first_acc[0][0]), 64'd1);
    #1;
    chk("t2_cnt0", cnt0a, 32'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Config packet with a data packet waiting: gap then one arbitration cycle
    push_pkt(0, 1, 0, 2);
    push_pkt(0, 0, 1, 2);
    last_acc[0][1] = 0;
    fork
      feed(0, 1, 0, 1, 2, 0);
      feed(0, 0, 1, 1, 2, 0);
      begin
        n = 0;
        while (last_acc[0][1] == 0 && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        #1;
        chk("t3_busy_in_gap", busy[0], 1'b1);
        chk("t3_tready_in_gap", s_tready[0], 2'b00);
      end
    join
    chk("t3_gap_latency", 64'(first_acc[0][0] - last_acc[0][1]), 64'd32);
    #1;
    chk("t3_cnt1", cnt1a, 32'd1);
    chk("t3_cnt0", cnt0a, 32'd2);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Round robin, no gap, both ports continuously valid; port 1 requests first
    for (int k = 0; k < 5; k++) begin
      push_pkt(1, 1, k, 3);
      push_pkt(1, 0, k, 3);
    end
    fork
      feed(1, 1, 0, 5, 3, 0);
      feed(1, 0, 0, 5, 3, 1);
    join
    chk("t4_span", 64'(last_acc[1][0] - first_acc[1][1]), 64'd38);
    #1;
    chk("t4_cnt0_wrap", cnt0b, 2'd1);
    chk("t4_cnt1_wrap", cnt1b, 2'd1);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Fixed priority to port 1, random output backpressure, single-beat data packets
    for (int k = 0; k < 4; k++) push_pkt(2, 1, k, 3);
    for (int k = 0; k < 3; k++) push_pkt(2, 0, k, 1);
    rand_on = 1'b1;
    fork
      begin
        fork
          feed(2, 1, 0, 4, 3, 0);
          feed(2, 0, 0, 3, 1, 0);
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          m_tready[2] = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
    join
    m_tready[2] = 1'b1;
    #1;
    chk("t5_cnt1", cnt1c, 32'd4);
    chk("t5_cnt0", cnt0c, 32'd3);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Reset in the middle of a data packet
    push_pkt(0, 0, 7, 1);
    sb[sb.size() - 1].keep = mk_keep(0, 3);
    sb[sb.size() - 1].last = 1'b0;
    s_tdata[0][0]  = mk_data(0, 7, 0);
    s_tkeep[0][0]  = mk_keep(0, 3);
    s_tuser[0][0]  = mk_user(0, 7, 0);
    s_tlast[0][0]  = 1'b0;
    s_tvalid[0][0] = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      #1;
      acc = s_tready[0][0];
      @(negedge clk);
      n++;
    end
    chk("t6_beat0_taken", acc, 1'b1);
    s_tvalid[0][0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_grant_held", busy[0], 1'b1);
    chk("t6_tready_held", s_tready[0], 2'b01);
    @(negedge clk);
    s_tdata[0][0]  = mk_data(0, 7, 1);
    s_tvalid[0][0] = 1'b1;
    #1;
    chk("t6_m_tvalid", m_tvalid[0], 1'b0);
    chk("t6_busy", busy[0], 1'b0);
    chk("t6_tready", s_tready[0], 2'b00);
    chk("t6_cnt0", cnt0a, 32'd0);
    @(negedge clk);
    s_tvalid[0][0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
